// File: rtl/finalproject_gpio_in_if.sv
// Avalon-MM slave port of the input PIO: register bus plus level interrupt.
// The master drives address/strobe/data; the slave returns registered readdata and irq.
interface finalproject_gpio_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/finalproject_gpio_in.sv
// Input PIO: synchronised level, sticky edge capture (W1C), masked level irq.
// Read latency 1 clock, irq 1 clock after EDGE; always ready, no backpressure.
module finalproject_gpio_in #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in_port,
  finalproject_gpio_in_if.slave bus
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] detected;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] mask;
  logic             ctrl;
  logic [WIDTH-1:0] clear;
  logic [31:0]      rd_next;
  logic             wr_mask;
  logic             wr_edge;
  logic             wr_ctrl;
  logic             unused_wdata;

  assign sync_out = sync_q[SYNC_STAGES-1];

  assign wr_mask = bus.chipselect & bus.write & (bus.address == 2'd1);
  assign wr_edge = bus.chipselect & bus.write & (bus.address == 2'd2);
  assign wr_ctrl = bus.chipselect & bus.write & (bus.address == 2'd3);
  assign clear   = wr_edge ? bus.writedata[WIDTH-1:0] : '0;

  // Upper write-data bits beyond WIDTH are architecturally ignored.
  assign unused_wdata = ^bus.writedata;

  always_comb begin
    detected = '0;
    case (EDGE_TYPE)
      0:       detected = sync_out & ~prev;
      1:       detected = ~sync_out & prev;
      default: detected = sync_out ^ prev;
    endcase
  end

  always_comb begin
    rd_next = '0;
    case (bus.address)
      2'd0: rd_next[WIDTH-1:0] = sync_out;
      2'd1: rd_next[WIDTH-1:0] = mask;
      2'd2: rd_next[WIDTH-1:0] = edge_cap;
      default: rd_next[0] = ctrl;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q       <= '0;
      prev         <= '0;
      edge_cap     <= '0;
      mask         <= '0;
      ctrl         <= 1'b0;
      bus.readdata <= '0;
      bus.irq      <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
      prev   <= sync_out;
      // A fresh edge in the same cycle as its clear keeps the bit set.
      edge_cap <= (edge_cap & ~clear) | detected;
      if (wr_mask) mask <= bus.writedata[WIDTH-1:0];
      if (wr_ctrl) ctrl <= bus.writedata[0];
      bus.readdata <= rd_next;
      bus.irq      <= ctrl & (|(edge_cap & mask));
    end
  end

endmodule

// File: tb/tb_finalproject_gpio_in.sv
// Directed bench for the input PIO: 8-bit rising-edge instance and 32-bit any-edge instance.
module tb_finalproject_gpio_in;

  logic        clk;
  logic        reset;
  logic [7:0]  in8;
  logic [31:0] in32;

  finalproject_gpio_in_if b8 ();
  finalproject_gpio_in_if b32 ();

  finalproject_gpio_in #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0)) dut8 (
    .clk(clk), .reset(reset), .in_port(in8), .bus(b8)
  );

  finalproject_gpio_in #(.WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(2)) dut32 (
    .clk(clk), .reset(reset), .in_port(in32), .bus(b32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        is_wr;
    logic [1:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    logic        exp_irq;
    string       name;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input bit sel, input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    if (sel) begin
      b32.address = a; b32.writedata = d; b32.chipselect = 1'b1; b32.write = 1'b1;
    end else begin
      b8.address = a; b8.writedata = d; b8.chipselect = 1'b1; b8.write = 1'b1;
    end
    @(negedge clk);
    b32.chipselect = 1'b0; b32.write = 1'b0;
    b8.chipselect  = 1'b0; b8.write  = 1'b0;
  endtask

  task automatic rd_chk(input bit sel, input logic [1:0] a, input logic [31:0] exp,
                        input logic exp_irq, input string name);
    @(negedge clk);
    if (sel) b32.address = a; else b8.address = a;
    @(negedge clk);
    chk({name, " rd"}, sel ? b32.readdata : b8.readdata, exp);
    chk({name, " irq"}, {31'd0, sel ? b32.irq : b8.irq}, {31'd0, exp_irq});
  endtask

  initial begin
    reset = 1'b1;
    in8   = 8'hFF;
    in32  = 32'h0;
    b8.address  = 2'd0; b8.chipselect  = 1'b0; b8.write  = 1'b0; b8.writedata  = 32'h0;
    b32.address = 2'd0; b32.chipselect = 1'b0; b32.write = 1'b0; b32.writedata = 32'h0;

    vecs[0]  = '{1'b1, 2'd1, 32'hFFFFFF01, 32'h0, 1'b0, "mask_wr_wide"};
    vecs[1]  = '{1'b0, 2'd1, 32'h0, 32'h00000001, 1'b0, "mask_upper_ignored"};
    vecs[2]  = '{1'b1, 2'd3, 32'hFFFFFFFF, 32'h0, 1'b0, "ctrl_wr_all"};
    vecs[3]  = '{1'b0, 2'd3, 32'h0, 32'h00000001, 1'b0, "ctrl_only_bit0"};
    vecs[4]  = '{1'b0, 2'd0, 32'h0, 32'h00000000, 1'b0, "data_low"};
    vecs[5]  = '{1'b0, 2'd2, 32'h0, 32'h00000000, 1'b0, "edge_empty"};
    vecs[6]  = '{1'b1, 2'd1, 32'h000000A5, 32'h0, 1'b0, "mask_wr_a5"};
    vecs[7]  = '{1'b0, 2'd1, 32'h0, 32'h000000A5, 1'b0, "mask_a5"};
    vecs[8]  = '{1'b1, 2'd2, 32'h000000FF, 32'h0, 1'b0, "edge_clr_empty"};
    vecs[9]  = '{1'b0, 2'd2, 32'h0, 32'h00000000, 1'b0, "edge_still_empty"};
    vecs[10] = '{1'b1, 2'd3, 32'h00000002, 32'h0, 1'b0, "ctrl_wr_bit1"};
    vecs[11] = '{1'b0, 2'd3, 32'h0, 32'h00000000, 1'b0, "ctrl_cleared"};

    // Reset state with inputs held high
    wait_n(3);
    chk("reset_rd8", b8.readdata, 32'h0);
    chk("reset_irq8", {31'd0, b8.irq}, 32'h0);
    chk("reset_rd32", b32.readdata, 32'h0);
    reset = 1'b0;
    wait_n(2);
    chk("data_before_sync", b8.readdata, 32'h0);
    wait_n(1);
    chk("data_after_sync", b8.readdata, 32'h000000FF);
    rd_chk(1'b0, 2'd2, 32'h000000FF, 1'b0, "edge_after_reset");
    wr(1'b0, 2'd2, 32'h000000FF);
    in8 = 8'h00;
    wait_n(5);
    rd_chk(1'b0, 2'd2, 32'h0, 1'b0, "falling_not_captured");

    // Register-level vector table
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].is_wr) wr(1'b0, vecs[i].addr, vecs[i].data);
      else rd_chk(1'b0, vecs[i].addr, vecs[i].exp_rd, vecs[i].exp_irq, vecs[i].name);
    end

    // Rising capture and irq latency
    wr(1'b0, 2'd1, 32'h01);
    wr(1'b0, 2'd3, 32'h01);
    in8[0] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk($sformatf("irq_latency_%0d", i), {31'd0, b8.irq}, {31'd0, (i == 4)});
    end
    rd_chk(1'b0, 2'd2, 32'h01, 1'b1, "rise_captured");
    in8[0] = 1'b0;
    wait_n(5);
    rd_chk(1'b0, 2'd2, 32'h01, 1'b1, "fall_no_capture");

    // Write-1-to-clear
    in8[2] = 1'b1;
    wait_n(5);
    rd_chk(1'b0, 2'd2, 32'h05, 1'b1, "edge_05");
    wr(1'b0, 2'd2, 32'h04);
    rd_chk(1'b0, 2'd2, 32'h01, 1'b1, "w1c_bit2");
    wr(1'b0, 2'd2, 32'h01);
    chk("irq_hold_at_clear", {31'd0, b8.irq}, 32'h1);
    @(negedge clk);
    chk("irq_drop_after_clear", {31'd0, b8.irq}, 32'h0);

    // Clear and edge landing on the same clock
    in8[3] = 1'b1;
    wait_n(5);
    rd_chk(1'b0, 2'd2, 32'h08, 1'b0, "bit3_set");
    in8[3] = 1'b0;
    wait_n(5);
    in8[3] = 1'b1;
    wait_n(2);
    b8.address = 2'd2; b8.writedata = 32'h08; b8.chipselect = 1'b1; b8.write = 1'b1;
    @(negedge clk);
    b8.chipselect = 1'b0; b8.write = 1'b0;
    rd_chk(1'b0, 2'd2, 32'h08, 1'b0, "detect_beats_clear");

    // Masking and global enable
    wr(1'b0, 2'd2, 32'hFF);
    in8[1] = 1'b1;
    wait_n(5);
    rd_chk(1'b0, 2'd2, 32'h02, 1'b0, "edge02_masked_out");
    wr(1'b0, 2'd3, 32'h0);
    wr(1'b0, 2'd1, 32'h02);
    wait_n(2);
    chk("irq_ctrl_off", {31'd0, b8.irq}, 32'h0);
    wr(1'b0, 2'd3, 32'h1);
    chk("irq_ctrl_just_on", {31'd0, b8.irq}, 32'h0);
    @(negedge clk);
    chk("irq_ctrl_on", {31'd0, b8.irq}, 32'h1);
    rd_chk(1'b0, 2'd0, 32'h0E, 1'b1, "data8_level");

    // 32-bit any-edge instance
    wr(1'b1, 2'd1, 32'h80000000);
    wr(1'b1, 2'd3, 32'h1);
    in32[31] = 1'b1;
    wait_n(5);
    rd_chk(1'b1, 2'd2, 32'h80000000, 1'b1, "b31_rise");
    wr(1'b1, 2'd2, 32'h80000000);
    @(negedge clk);
    chk("b31_irq_cleared", {31'd0, b32.irq}, 32'h0);
    rd_chk(1'b1, 2'd2, 32'h0, 1'b0, "b31_edge_cleared");
    in32[31] = 1'b0;
    wait_n(5);
    rd_chk(1'b1, 2'd2, 32'h80000000, 1'b1, "b31_fall");
    wr(1'b1, 2'd3, 32'hFFFFFFFF);
    rd_chk(1'b1, 2'd3, 32'h00000001, 1'b1, "ctrl32");
    in32 = 32'h12345678;
    wait_n(5);
    rd_chk(1'b1, 2'd0, 32'h12345678, 1'b1, "data32");

    // Asynchronous reset mid-operation
    #2;
    reset = 1'b1;
    #1;
    chk("async_irq32", {31'd0, b32.irq}, 32'h0);
    chk("async_rd32", b32.readdata, 32'h0);
    chk("async_irq8", {31'd0, b8.irq}, 32'h0);
    wait_n(1);
    reset = 1'b0;
    rd_chk(1'b1, 2'd1, 32'h0, 1'b0, "mask32_after_reset");
    rd_chk(1'b1, 2'd3, 32'h0, 1'b0, "ctrl32_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
